// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle sequencer for the nano_riscv core.
// Drives the one-hot datapath state bus, arbitrates the shared memory port
// between instruction fetch and load/store data access, and provides halt
// control plus a memory-response timeout that latches a sticky bus error.
//
// state | meaning
// ------+----------------------------------------------------------------
// IF    | fetch: request instruction at PC, wait for mem_ready
// EX    | execute: instruction on mem_rdata; ALU ops retire here
// MEM   | data access for a load/store, wait for mem_ready
// WB    | load data on mem_rdata; load/store retires here
module core_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       halt,
  input  logic       is_ls,
  input  logic       is_store,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       inst_L,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       pc_we,
  output logic       rd_we,
  output logic       bus_err,
  output logic       halted
);

  typedef enum logic [3:0] {
    ST_IF  = 4'b0001,
    ST_EX  = 4'b0010,
    ST_MEM = 4'b0100,
    ST_WB  = 4'b1000
  } state_e;

  // Last count value before the timeout fires; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_e           state_q,    state_d;
  logic             inst_l_q,   inst_l_d;
  logic             is_store_q, is_store_d;
  logic             req_act_q,  req_act_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q,  bus_err_d;

  logic st_if, st_ex, st_mem, st_wb;
  logic stall;
  logic cnt_sat;
  logic timeout_hit;

  assign st_if  = state_q[0];
  assign st_ex  = state_q[1];
  assign st_mem = state_q[2];
  assign st_wb  = state_q[3];

  // A started fetch keeps requesting even if halt rises; a new fetch is
  // only started when neither halt nor a bus error is present.
  assign mem_req  = (st_if & (req_act_q | (~halt & ~bus_err_q))) | st_mem;
  assign addr_sel = st_mem;
  assign mem_we   = st_mem & is_store_q;
  assign pc_we    = (st_ex & ~is_ls) | st_wb;
  assign rd_we    = (st_ex & ~is_ls) | (st_wb & ~is_store_q);
  assign halted   = st_if & ~mem_req;
  assign state    = state_q;
  assign inst_L   = inst_l_q;
  assign bus_err  = bus_err_q;

  assign stall       = mem_req & ~mem_ready;
  assign cnt_sat     = &wait_cnt_q;
  // mem_ready in the same cycle masks the timeout, so ready always wins.
  assign timeout_hit = (TIMEOUT != 0) && stall && (wait_cnt_q == TO_LAST);

  // Next-state logic for the sequencer, wait counter and error flag.
  always_comb begin
    state_d    = state_q;
    inst_l_d   = inst_l_q;
    is_store_d = is_store_q;
    req_act_d  = req_act_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;

    unique case (state_q)
      ST_IF: begin
        if (mem_req) begin
          if (mem_ready) begin
            state_d   = ST_EX;
            req_act_d = 1'b0;
          end else begin
            req_act_d = 1'b1;
          end
        end
      end
      ST_EX: begin
        if (is_ls) begin
          state_d    = ST_MEM;
          inst_l_d   = 1'b1;
          is_store_d = is_store;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        state_d  = ST_IF;
        inst_l_d = 1'b0;
      end
      default: begin
        state_d   = ST_IF;
        inst_l_d  = 1'b0;
        req_act_d = 1'b0;
      end
    endcase

    // Counter measures stall length of the current request only.
    if (mem_ready || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (stall && !cnt_sat) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // Timeout abandons the request and parks the core in IF for good.
    if (timeout_hit) begin
      bus_err_d  = 1'b1;
      req_act_d  = 1'b0;
      wait_cnt_d = '0;
      state_d    = ST_IF;
      inst_l_d   = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IF;
      inst_l_q   <= 1'b0;
      is_store_q <= 1'b0;
      req_act_q  <= 1'b0;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inst_l_q   <= inst_l_d;
      is_store_q <= is_store_d;
      req_act_q  <= req_act_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_core_ctrl;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       halt = 1'b0;
  logic       is_ls = 1'b0;
  logic       is_store = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] state;
  logic       inst_L, mem_req, mem_we, addr_sel, pc_we, rd_we, bus_err, halted;

  int checks = 0;
  int errors = 0;

  core_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn), .halt(halt), .is_ls(is_ls), .is_store(is_store),
    .mem_ready(mem_ready), .state(state), .inst_L(inst_L), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .pc_we(pc_we), .rd_we(rd_we),
    .bus_err(bus_err), .halted(halted)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0=fetch 1=execute 2=data access 3=writeback.
  int m_ph    = 0;
  int m_wait  = 0;
  bit m_pend  = 0;
  bit m_err   = 0;
  bit m_st    = 0;
  bit m_valid = 0;

  function automatic bit e_req();
    return (m_ph == 0 && (m_pend || (!halt && !m_err))) || m_ph == 2;
  endfunction

  task automatic m_stall();
    if (m_wait + 1 >= TO) begin
      m_err = 1; m_pend = 0; m_wait = 0; m_ph = 0;
    end else begin
      m_wait++;
      if (m_ph == 0) m_pend = 1;
    end
  endtask

  always @(posedge clk) begin
    if (!rstn) begin
      m_ph = 0; m_wait = 0; m_pend = 0; m_err = 0; m_st = 0; m_valid = 1;
    end else if (m_valid) begin
      case (m_ph)
        0: if (e_req()) begin
             if (mem_ready) begin m_ph = 1; m_pend = 0; m_wait = 0; end
             else m_stall();
           end
        1: begin
             m_wait = 0;
             if (is_ls) begin m_ph = 2; m_st = is_store; end
             else m_ph = 0;
           end
        2: if (mem_ready) begin m_ph = 3; m_wait = 0; end
           else m_stall();
        default: begin m_ph = 0; m_wait = 0; end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      bit r;
      r = e_req();
      chk("state",    state,             4'(1 << m_ph));
      chk("inst_L",   {3'b0, inst_L},    {3'b0, (m_ph == 2 || m_ph == 3)});
      chk("mem_req",  {3'b0, mem_req},   {3'b0, r});
      chk("addr_sel", {3'b0, addr_sel},  {3'b0, m_ph == 2});
      chk("mem_we",   {3'b0, mem_we},    {3'b0, (m_ph == 2 && m_st)});
      chk("pc_we",    {3'b0, pc_we},     {3'b0, ((m_ph == 1 && !is_ls) || m_ph == 3)});
      chk("rd_we",    {3'b0, rd_we},     {3'b0, ((m_ph == 1 && !is_ls) || (m_ph == 3 && !m_st))});
      chk("bus_err",  {3'b0, bus_err},   {3'b0, m_err});
      chk("halted",   {3'b0, halted},    {3'b0, (m_ph == 0 && !r)});
    end
  end

  task automatic cyc(input bit r, input bit h, input bit ls, input bit st, input bit rdy);
    @(posedge clk);
    #1;
    rstn = r; halt = h; is_ls = ls; is_store = st; mem_ready = rdy;
    @(negedge clk);
  endtask

  int p_tab[5] = '{100, 70, 30, 5, 0};
  bit h_r = 0;

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // ALU instructions, zero-wait memory
    cyc(1, 0, 0, 0, 1);
    chk("L_rst_state", state, 4'b0001); chk("L_rst_req", {3'b0, mem_req}, 4'd1);
    chk("L_rst_instL", {3'b0, inst_L}, 4'd0); chk("L_rst_err", {3'b0, bus_err}, 4'd0);
    cyc(1, 0, 0, 0, 1);
    chk("L_alu_ex", state, 4'b0010); chk("L_alu_pc", {3'b0, pc_we}, 4'd1);
    chk("L_alu_rd", {3'b0, rd_we}, 4'd1);
    cyc(1, 0, 0, 0, 1); chk("L_alu_if2", state, 4'b0001);
    cyc(1, 0, 0, 0, 1); chk("L_alu_ex2", state, 4'b0010);

    // Load, zero-wait
    cyc(1, 0, 1, 0, 1); chk("L_ld_if", state, 4'b0001);
    cyc(1, 0, 1, 0, 1); chk("L_ld_ex", state, 4'b0010); chk("L_ld_ex_instL", {3'b0, inst_L}, 4'd0);
    cyc(1, 0, 1, 0, 1); chk("L_ld_mem", state, 4'b0100);
    chk("L_ld_mem_instL", {3'b0, inst_L}, 4'd1); chk("L_ld_addr", {3'b0, addr_sel}, 4'd1);
    cyc(1, 0, 0, 0, 1); chk("L_ld_wb", state, 4'b1000);
    chk("L_ld_wb_rd", {3'b0, rd_we}, 4'd1); chk("L_ld_wb_pc", {3'b0, pc_we}, 4'd1);

    // Store with three wait cycles in MEM
    cyc(1, 0, 1, 1, 1); chk("L_st_if", state, 4'b0001); chk("L_st_if_instL", {3'b0, inst_L}, 4'd0);
    cyc(1, 0, 1, 1, 0); chk("L_st_ex", state, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, i == 3);
      chk("L_st_mem", state, 4'b0100); chk("L_st_we", {3'b0, mem_we}, 4'd1);
    end
    cyc(1, 0, 0, 0, 0); chk("L_st_wb", state, 4'b1000);
    chk("L_st_wb_rd", {3'b0, rd_we}, 4'd0); chk("L_st_wb_pc", {3'b0, pc_we}, 4'd1);

    // Halt rises after the fetch request starts
    cyc(1, 0, 0, 0, 0); chk("L_h_req0", {3'b0, mem_req}, 4'd1);
    cyc(1, 1, 0, 0, 0); chk("L_h_req1", {3'b0, mem_req}, 4'd1);
    cyc(1, 1, 0, 0, 0); chk("L_h_req2", {3'b0, mem_req}, 4'd1);
    cyc(1, 1, 0, 0, 1); chk("L_h_req3", {3'b0, mem_req}, 4'd1);
    cyc(1, 1, 0, 0, 0); chk("L_h_ex", state, 4'b0010);
    cyc(1, 1, 0, 0, 0); chk("L_h_idle_req", {3'b0, mem_req}, 4'd0);
    chk("L_h_halted", {3'b0, halted}, 4'd1);

    // Halt released, memory never answers: timeout after 8 request cycles
    for (int i = 0; i < TO; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("L_to_req", {3'b0, mem_req}, 4'd1); chk("L_to_noerr", {3'b0, bus_err}, 4'd0);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, bit'($urandom_range(0, 1)));
      chk("L_to_err", {3'b0, bus_err}, 4'd1); chk("L_to_req0", {3'b0, mem_req}, 4'd0);
      chk("L_to_halted", {3'b0, halted}, 4'd1);
    end

    // Reset in the middle of a stalled MEM
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1); chk("L_r_if", state, 4'b0001); chk("L_r_err", {3'b0, bus_err}, 4'd0);
    cyc(1, 0, 1, 0, 0); chk("L_r_ex", state, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0); chk("L_r_mem", state, 4'b0100);
    end
    cyc(0, 0, 0, 0, 0); chk("L_r_mem_rst", state, 4'b0100);
    cyc(1, 0, 0, 0, 0); chk("L_r_post_state", state, 4'b0001);
    chk("L_r_post_instL", {3'b0, inst_L}, 4'd0); chk("L_r_post_req", {3'b0, mem_req}, 4'd1);
    chk("L_r_post_addr", {3'b0, addr_sel}, 4'd0);
    for (int i = 0; i < TO - 2; i++) begin
      cyc(1, 0, 0, 0, 0); chk("L_r_cnt_noerr", {3'b0, bus_err}, 4'd0);
    end
    // Eighth stalled cycle: ready arrives together with the timeout point
    cyc(1, 0, 0, 0, 1); chk("L_r_last_noerr", {3'b0, bus_err}, 4'd0);
    cyc(1, 0, 0, 0, 0); chk("L_ready_wins", state, 4'b0010);
    chk("L_ready_wins_err", {3'b0, bus_err}, 4'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int p;
      bit r;
      p = p_tab[(i / 150) % 5];
      r = !($urandom_range(0, 249) == 0 || (m_err && $urandom_range(0, 9) == 0));
      if ($urandom_range(0, 19) == 0) h_r = !h_r;
      cyc(r, h_r, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          $urandom_range(0, 99) < p);
    end

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
